// File: rtl/rst_ctrl_if.sv
// CPU-side register bus of the reset controller: select, write strobe, address, data.
// Combinational read data; no handshake or backpressure.
interface rst_ctrl_if;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, output we, output addr, output din, input dout);
    modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/rst_ctrl.sv
// Sequenced SoC reset: collects POR, debounced button, watchdog and soft triggers into periph/cpu resets.
// Outputs registered, reset asserted the edge a trigger is sampled; register reads combinational; no backpressure.
module rst_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int DEBOUNCE    = 200
) (
    input  logic        clk,
    input  logic        rst,
    rst_ctrl_if.slave   bus,
    input  logic        btn_n,
    input  logic        wdt_reset,
    input  logic        halt,
    output logic        periph_rst,
    output logic        cpu_rst,
    output logic        wdt_rst,
    output logic        wdt_pause_n
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STAG_LAST = 8'(STAGGER - 1);
    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE - 1);

    typedef enum logic [1:0] {ST_HOLD, ST_STAGGER, ST_RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cause_q;
    logic [1:0] ctrl_q;
    logic [7:0] count_q;
    logic       soft_q;
    logic       btn_s1, btn_s2, btn_lvl, btn_lvl_d;
    logic [7:0] deb_cnt;

    logic       wr, in_run, btn_trig, trig_any;
    logic [3:0] cause_set, cause_clr;

    assign wr        = bus.cs & bus.we;
    assign in_run    = (state_q == ST_RUN);
    assign btn_trig  = btn_lvl_d & ~btn_lvl & ctrl_q[1];
    assign trig_any  = btn_trig | wdt_reset | soft_q;
    assign cause_set = {soft_q, wdt_reset, btn_trig, 1'b0};
    assign cause_clr = (wr && bus.addr == 2'd0) ? bus.din[3:0] : 4'b0000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_STAGGER;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STAGGER: begin
                if (cnt_q == STAG_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: ;
            default: begin
                state_d = ST_HOLD;
                cnt_d   = 8'd0;
            end
        endcase
        // A trigger in any state restarts the full hold window.
        if (trig_any) begin
            state_d = ST_HOLD;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            cnt_q       <= 8'd0;
            periph_rst  <= 1'b1;
            wdt_rst     <= 1'b1;
            cpu_rst     <= 1'b1;
            wdt_pause_n <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            periph_rst  <= (state_d == ST_HOLD);
            wdt_rst     <= (state_d == ST_HOLD);
            cpu_rst     <= (state_d != ST_RUN);
            wdt_pause_n <= (state_d == ST_RUN) && !(ctrl_q[0] && halt);
        end
    end

    // Button: 2-flop synchronizer, then accept a level only after DEBOUNCE equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b1;
            btn_s2    <= 1'b1;
            btn_lvl   <= 1'b1;
            btn_lvl_d <= 1'b1;
            deb_cnt   <= 8'd0;
        end else begin
            btn_s1    <= btn_n;
            btn_s2    <= btn_s1;
            btn_lvl_d <= btn_lvl;
            if (btn_s2 != btn_lvl) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_lvl <= btn_s2;
                    deb_cnt <= 8'd0;
                end else begin
                    deb_cnt <= deb_cnt + 8'd1;
                end
            end else begin
                deb_cnt <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= 4'b0001;
            ctrl_q  <= 2'b10;
            count_q <= 8'd0;
            soft_q  <= 1'b0;
        end else begin
            cause_q <= (cause_q & ~cause_clr) | cause_set;
            soft_q  <= wr && in_run && bus.addr == 2'd2 && bus.din == 8'hA5;
            if (wr && in_run && bus.addr == 2'd1)
                ctrl_q <= bus.din[1:0];
            if (trig_any && in_run && count_q != 8'hFF)
                count_q <= count_q + 8'd1;
        end
    end

    always_comb begin
        bus.dout = 8'h00;
        if (bus.cs) begin
            case (bus.addr)
                2'd0:    bus.dout = {4'b0000, cause_q};
                2'd1:    bus.dout = {6'b000000, ctrl_q};
                2'd3:    bus.dout = count_q;
                default: bus.dout = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_ctrl.sv
// Randomized and directed bench for rst_ctrl against a cycle-indexed reference model.
module tb_rst_ctrl;
    localparam int H = 16;
    localparam int S = 4;
    localparam int D = 200;

    logic clk;
    logic rst, btn_n, wdt_reset, halt;
    logic periph_rst, cpu_rst, wdt_rst, wdt_pause_n;

    rst_ctrl_if bus ();

    rst_ctrl #(.HOLD_CYCLES(H), .STAGGER(S), .DEBOUNCE(D)) dut (
        .clk(clk), .rst(rst), .bus(bus), .btn_n(btn_n), .wdt_reset(wdt_reset),
        .halt(halt), .periph_rst(periph_rst), .cpu_rst(cpu_rst),
        .wdt_rst(wdt_rst), .wdt_pause_n(wdt_pause_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: resets are described by the edge of the most recent trigger.
    int         cyc = 0;
    int         trig_edge = 0;
    int         last_rst = 0;
    bit         hist [0:65535];
    logic [3:0] m_cause;
    logic [1:0] m_ctrl;
    int         m_count;
    bit         soft_pend, m_level, m_fell, m_gate;

    function automatic bit samp(input int i);
        if (i < 1 || i <= last_rst) return 1'b1;
        return hist[i];
    endfunction

    function automatic logic [7:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {4'b0000, m_cause};
            2'd1:    return {6'b000000, m_ctrl};
            2'd3:    return m_count[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        bit run_before, bt, wt, st, any, all_eq, v, lvl_old, wr;
        logic [3:0] set_b, clr_b;
        cyc++;
        hist[cyc] = btn_n;
        if (rst) begin
            m_cause = 4'b0001; m_ctrl = 2'b10; m_count = 0;
            trig_edge = cyc; last_rst = cyc;
            soft_pend = 0; m_level = 1; m_fell = 0; m_gate = 0;
            return;
        end
        run_before = (cyc - 1) >= trig_edge + H + S;
        wr = bus.cs && bus.we;
        m_gate = m_ctrl[0] && halt;
        bt = m_fell && m_ctrl[1];
        lvl_old = m_level;
        v = samp(cyc - 2);
        all_eq = 1;
        for (int j = 0; j < D; j++)
            if (samp(cyc - 2 - j) != v) all_eq = 0;
        if (all_eq && v != m_level) m_level = v;
        m_fell = lvl_old && !m_level;
        st = soft_pend;
        soft_pend = wr && run_before && bus.addr == 2'd2 && bus.din == 8'hA5;
        wt = wdt_reset;
        any = bt || wt || st;
        set_b = {st, wt, bt, 1'b0};
        clr_b = (wr && bus.addr == 2'd0) ? bus.din[3:0] : 4'b0000;
        m_cause = (m_cause & ~clr_b) | set_b;
        if (wr && run_before && bus.addr == 2'd1) m_ctrl = bus.din[1:0];
        if (any && run_before && m_count < 255) m_count++;
        if (any) trig_edge = cyc;
    endtask

    task automatic cycles(input int k);
        bit e_periph, e_cpu, e_pause;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            e_periph = cyc < trig_edge + H;
            e_cpu    = cyc < trig_edge + H + S;
            e_pause  = !e_cpu && !m_gate;
            chk("periph_rst", 32'(periph_rst), 32'(e_periph));
            chk("wdt_rst", 32'(wdt_rst), 32'(e_periph));
            chk("cpu_rst", 32'(cpu_rst), 32'(e_cpu));
            chk("wdt_pause_n", 32'(wdt_pause_n), 32'(e_pause));
            if (!bus.cs) chk("dout_idle", 32'(bus.dout), 32'h0);
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        bus.cs = 1; bus.we = 1; bus.addr = a; bus.din = d;
        cycles(1);
        bus.cs = 0; bus.we = 0;
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus.cs = 1; bus.we = 0; bus.addr = a;
        #1;
        chk(tag, 32'(bus.dout), 32'(exp));
        chk({tag, "_model"}, 32'(bus.dout), 32'(model_rd(a)));
        #1;
        bus.cs = 0;
    endtask

    task automatic bounce();
        for (int p = 0; p < 3; p++) begin
            btn_n = 0; cycles(50);
            btn_n = 1; cycles(50);
        end
        btn_n = 0; cycles(300);
        btn_n = 1; cycles(300);
    endtask

    int cnt_before;

    initial begin
        rst = 1; btn_n = 1; wdt_reset = 0; halt = 0;
        bus.cs = 0; bus.we = 0; bus.addr = 0; bus.din = 0;

        cycles(3);
        rst = 0;
        cycles(30);
        rd_reg("por_cause", 2'd0, 8'h01);
        rd_reg("por_count", 2'd3, 8'h00);
        rd_reg("por_ctrl", 2'd1, 8'h02);

        wdt_reset = 1; cycles(1); wdt_reset = 0;
        cycles(30);
        rd_reg("wdt_cause", 2'd0, 8'h05);
        rd_reg("wdt_count", 2'd3, 8'h01);
        rd_reg("wdt_ctrl", 2'd1, 8'h02);

        wr_reg(2'd0, 8'h0F);
        bounce();
        rd_reg("btn_cause", 2'd0, 8'h02);
        rd_reg("btn_count", 2'd3, 8'h02);

        wr_reg(2'd1, 8'h00);
        wr_reg(2'd0, 8'h0F);
        bounce();
        rd_reg("btn_off_cause", 2'd0, 8'h00);
        rd_reg("btn_off_count", 2'd3, 8'h02);
        wr_reg(2'd1, 8'h02);

        wr_reg(2'd2, 8'h5A);
        cycles(30);
        rd_reg("soft_5a_cause", 2'd0, 8'h00);
        wr_reg(2'd2, 8'hA5);
        cycles(30);
        rd_reg("soft_a5_cause", 2'd0, 8'h08);
        rd_reg("soft_read", 2'd2, 8'h00);
        wr_reg(2'd0, 8'h0F);
        rd_reg("cause_clr", 2'd0, 8'h00);

        // Button trigger lands ten cycles into a watchdog-started hold.
        cnt_before = m_count;
        btn_n = 0;
        cycles(191);
        wdt_reset = 1; cycles(1); wdt_reset = 0;
        cycles(40);
        rd_reg("retrig_cause", 2'd0, 8'h06);
        rd_reg("retrig_count", 2'd3, 8'(cnt_before + 1));
        btn_n = 1;
        cycles(300);

        wr_reg(2'd1, 8'h01);
        cycles(2);
        halt = 1; cycles(1);
        chk("halt_pause", 32'(wdt_pause_n), 32'h0);
        halt = 0; cycles(1);
        chk("unhalt_pause", 32'(wdt_pause_n), 32'h1);
        wr_reg(2'd1, 8'h02);

        for (int i = 0; i < 256; i++) begin
            wdt_reset = 1; cycles(1); wdt_reset = 0;
            cycles(22);
        end
        rd_reg("count_sat", 2'd3, 8'hFF);

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) rst = 1;
            if (i == 2002) rst = 0;
            wdt_reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) halt = ~halt;
            if ($urandom_range(0, 349) == 0) btn_n = ~btn_n;
            if ($urandom_range(0, 15) == 0) begin
                bus.cs = 1; bus.we = 1;
                bus.addr = 2'($urandom_range(0, 3));
                bus.din = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
            end
            cycles(1);
            bus.cs = 0; bus.we = 0;
            if ($urandom_range(0, 31) == 0) begin
                bus.addr = 2'($urandom_range(0, 3));
                rd_reg("rand_read", bus.addr, model_rd(bus.addr));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
